// File: rtl/exception_ctrl_pkg.sv
// rtl/exception_ctrl_pkg.sv - exception codes, CP0 bit indices, FSM states and priority helper
package exception_ctrl_pkg;

    localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
    localparam logic [31:0] EXC_INT     = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] EXC_RI      = 32'h0000_000a;
    localparam logic [31:0] EXC_OV      = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;

    // Bit positions inside exc_req: {eret, syscall, trap, ov, ri}
    localparam int REQ_RI      = 0;
    localparam int REQ_OV      = 1;
    localparam int REQ_TRAP    = 2;
    localparam int REQ_SYSCALL = 3;
    localparam int REQ_ERET    = 4;

    localparam logic [5:0] STALL_ALL  = 6'b111111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_WAIT_BUS = 2'd1,
        ST_FLUSH    = 2'd2
    } exc_state_t;

    function automatic logic [31:0] exc_encode(input logic int_pending, input logic [4:0] req);
        logic [31:0] code;
        code = EXC_NONE;
        if (int_pending)            code = EXC_INT;
        else if (req[REQ_RI])       code = EXC_RI;
        else if (req[REQ_OV])       code = EXC_OV;
        else if (req[REQ_TRAP])     code = EXC_TRAP;
        else if (req[REQ_SYSCALL])  code = EXC_SYSCALL;
        else if (req[REQ_ERET])     code = EXC_ERET;
        return code;
    endfunction

endpackage

// File: rtl/exception_ctrl_if.sv
// rtl/exception_ctrl_if.sv - pipeline/CP0/bus signals seen by the exception controller
interface exception_ctrl_if;

    logic        stallreq_if_i;
    logic        stallreq_id_i;
    logic        stallreq_ex_i;
    logic        stallreq_mem_i;
    logic        mem_inst_valid_i;
    logic [31:0] mem_pc_i;
    logic        mem_in_delayslot_i;
    logic [4:0]  exc_req_i;
    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic [31:0] epc_i;
    logic        bus_busy_i;

    logic [31:0] exception_type_o;
    logic [31:0] exc_pc_o;
    logic        exc_delayslot_o;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;

    modport master (
        input  stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        input  mem_inst_valid_i, mem_pc_i, mem_in_delayslot_i, exc_req_i,
        input  status_i, cause_i, epc_i, bus_busy_i,
        output exception_type_o, exc_pc_o, exc_delayslot_o, stall_o, flush_o, new_pc_o
    );

    modport slave (
        output stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        output mem_inst_valid_i, mem_pc_i, mem_in_delayslot_i, exc_req_i,
        output status_i, cause_i, epc_i, bus_busy_i,
        input  exception_type_o, exc_pc_o, exc_delayslot_o, stall_o, flush_o, new_pc_o
    );

endinterface

// File: rtl/exception_ctrl_int_synchronizer.sv
// rtl/exception_ctrl_int_synchronizer.sv - multi-stage flop chain for asynchronous interrupt lines
module int_synchronizer #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STAGES; i++) chain[i] <= '0;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/exception_ctrl.sv
// rtl/exception_ctrl.sv - exception entry/return sequencer beside CP0: prioritise, stall, commit, flush, redirect
module exception_ctrl
    import exception_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int          FLUSH_CYCLES = 2,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       hw_int_i,
    output logic [5:0]       int_sync_o,
    exception_ctrl_if.master bus
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    exc_state_t  state;
    logic [3:0]  flush_cnt;
    logic [31:0] lat_code;
    logic [31:0] lat_pc;
    logic [31:0] lat_target;
    logic        lat_ds;

    logic        int_pending;
    logic        detect;
    logic [31:0] det_code;
    logic [31:0] det_target;
    logic [5:0]  run_stall;
    logic        unused_cp0_bits;

    int_synchronizer #(.STAGES(SYNC_STAGES), .WIDTH(6)) u_int_sync (
        .clk (clk),
        .rst (rst),
        .d   (hw_int_i),
        .q   (int_sync_o)
    );

    assign int_pending = (|(bus.cause_i[15:8] & bus.status_i[15:8]))
                       & bus.status_i[STATUS_IE] & ~bus.status_i[STATUS_EXL];
    assign det_code    = exc_encode(int_pending, bus.exc_req_i);
    assign detect      = (state == ST_RUN) && bus.mem_inst_valid_i && (det_code != EXC_NONE);
    assign det_target  = (det_code == EXC_ERET) ? bus.epc_i : EXC_VECTOR;

    assign unused_cp0_bits = ^{bus.status_i[31:16], bus.status_i[7:2],
                               bus.cause_i[31:16], bus.cause_i[7:0]};

    always_comb begin
        run_stall = STALL_NONE;
        if (bus.stallreq_mem_i)                          run_stall = STALL_MEM;
        else if (bus.stallreq_ex_i)                      run_stall = STALL_EX;
        else if (bus.stallreq_id_i || bus.stallreq_if_i) run_stall = STALL_ID;
    end

    // The detect cycle must freeze the pipeline before the FSM has registered anything.
    always_comb begin
        bus.stall_o = STALL_NONE;
        if (rst) begin
            case (state)
                ST_RUN:      bus.stall_o = detect ? STALL_ALL : run_stall;
                ST_WAIT_BUS: bus.stall_o = STALL_ALL;
                default:     bus.stall_o = STALL_NONE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                <= ST_RUN;
            flush_cnt            <= '0;
            lat_code             <= '0;
            lat_pc               <= '0;
            lat_target           <= '0;
            lat_ds               <= 1'b0;
            bus.flush_o          <= 1'b0;
            bus.new_pc_o         <= '0;
            bus.exception_type_o <= '0;
            bus.exc_pc_o         <= '0;
            bus.exc_delayslot_o  <= 1'b0;
        end else begin
            bus.exception_type_o <= EXC_NONE;
            bus.exc_pc_o         <= '0;
            bus.exc_delayslot_o  <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (detect) begin
                        lat_code   <= det_code;
                        lat_pc     <= bus.mem_pc_i;
                        lat_ds     <= bus.mem_in_delayslot_i;
                        lat_target <= det_target;
                        if (bus.bus_busy_i) begin
                            state <= ST_WAIT_BUS;
                        end else begin
                            state                <= ST_FLUSH;
                            flush_cnt            <= FLUSH_LOAD;
                            bus.flush_o          <= 1'b1;
                            bus.new_pc_o         <= det_target;
                            bus.exception_type_o <= det_code;
                            bus.exc_pc_o         <= bus.mem_pc_i;
                            bus.exc_delayslot_o  <= bus.mem_in_delayslot_i;
                        end
                    end
                end
                ST_WAIT_BUS: begin
                    if (!bus.bus_busy_i) begin
                        state                <= ST_FLUSH;
                        flush_cnt            <= FLUSH_LOAD;
                        bus.flush_o          <= 1'b1;
                        bus.new_pc_o         <= lat_target;
                        bus.exception_type_o <= lat_code;
                        bus.exc_pc_o         <= lat_pc;
                        bus.exc_delayslot_o  <= lat_ds;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == 4'd0) begin
                        state        <= ST_RUN;
                        bus.flush_o  <= 1'b0;
                        bus.new_pc_o <= '0;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_exception_ctrl.sv
// tb/tb_exception_ctrl.sv - self-checking bench for exception_ctrl with a cycle-level reference model
module tb_exception_ctrl;

    localparam logic [31:0] VEC = 32'hBFC00380;
    localparam int          FC  = 2;
    localparam int          SS  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] hw_int;
    logic [5:0] int_sync;
    int         checks   = 0;
    int         failures = 0;

    exception_ctrl_if bus ();

    exception_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC), .SYNC_STAGES(SS)) dut (
        .clk        (clk),
        .rst        (rst),
        .hw_int_i   (hw_int),
        .int_sync_o (int_sync),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] classify(input logic [31:0] st, input logic [31:0] cs,
                                             input logic [4:0] req);
        if (((cs[15:8] & st[15:8]) != 8'h00) && st[0] && !st[1]) return 32'h01;
        if (req[0]) return 32'h0a;
        if (req[1]) return 32'h0c;
        if (req[2]) return 32'h0d;
        if (req[3]) return 32'h08;
        if (req[4]) return 32'h0e;
        return 32'h00;
    endfunction

    // Reference model: an exception is an event at cycle N; its flush window is scheduled
    // from the first cycle >= N in which the bus is idle.
    int          m_cyc;
    bit          m_active;
    int          m_fstart;
    logic [31:0] m_code;
    logic [31:0] m_target;
    logic [31:0] m_pc;
    logic        m_ds;
    logic [5:0]  sync_q [$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q.delete();
        end else begin
            sync_q.push_front(hw_int);
            if (sync_q.size() > SS) void'(sync_q.pop_back());
        end
    end

    always @(negedge clk) begin
        logic [5:0]  e_stall;
        logic        e_flush;
        logic [31:0] e_type;
        logic [31:0] e_code;
        logic [5:0]  e_sync;
        bit          commit;
        e_sync = (sync_q.size() == SS) ? sync_q[SS-1] : 6'd0;
        if (!rst) begin
            m_cyc    = 0;
            m_active = 0;
            m_fstart = -1;
            chk("rst_stall",    32'(bus.stall_o),         32'h0);
            chk("rst_flush",    32'(bus.flush_o),         32'h0);
            chk("rst_type",     bus.exception_type_o,     32'h0);
            chk("rst_new_pc",   bus.new_pc_o,             32'h0);
            chk("rst_exc_pc",   bus.exc_pc_o,             32'h0);
            chk("rst_ds",       32'(bus.exc_delayslot_o), 32'h0);
            chk("rst_int_sync", 32'(int_sync),            32'h0);
        end else begin
            m_cyc++;
            e_stall = 6'd0;
            e_flush = 1'b0;
            e_type  = 32'h0;
            commit  = 0;
            if (m_active && m_fstart >= 0 && m_cyc >= m_fstart + FC) m_active = 0;
            if (!m_active) begin
                e_code = classify(bus.status_i, bus.cause_i, bus.exc_req_i);
                if (bus.mem_inst_valid_i && e_code != 32'h0) begin
                    e_stall  = 6'b111111;
                    m_active = 1;
                    m_code   = e_code;
                    m_pc     = bus.mem_pc_i;
                    m_ds     = bus.mem_in_delayslot_i;
                    m_target = (e_code == 32'h0e) ? bus.epc_i : VEC;
                    m_fstart = bus.bus_busy_i ? -1 : m_cyc + 1;
                end else if (bus.stallreq_mem_i) e_stall = 6'b011111;
                else if (bus.stallreq_ex_i)      e_stall = 6'b001111;
                else if (bus.stallreq_id_i || bus.stallreq_if_i) e_stall = 6'b000111;
            end else if (m_fstart < 0) begin
                e_stall = 6'b111111;
                if (!bus.bus_busy_i) m_fstart = m_cyc + 1;
            end else begin
                e_flush = 1'b1;
                if (m_cyc == m_fstart) begin
                    e_type = m_code;
                    commit = 1;
                end
            end
            chk("m_stall",    32'(bus.stall_o),     32'(e_stall));
            chk("m_flush",    32'(bus.flush_o),     32'(e_flush));
            chk("m_type",     bus.exception_type_o, e_type);
            chk("m_int_sync", 32'(int_sync),        32'(e_sync));
            if (e_flush) chk("m_new_pc", bus.new_pc_o, m_target);
            if (commit) begin
                chk("m_exc_pc", bus.exc_pc_o,              m_pc);
                chk("m_exc_ds", 32'(bus.exc_delayslot_o),  32'(m_ds));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_mem();
        bus.mem_inst_valid_i   = 1'b0;
        bus.exc_req_i          = 5'b0;
        bus.mem_in_delayslot_i = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        hw_int = 6'd0;
        bus.stallreq_if_i = 1'b0;  bus.stallreq_id_i = 1'b0;
        bus.stallreq_ex_i = 1'b0;  bus.stallreq_mem_i = 1'b0;
        bus.mem_pc_i = 32'h0;      bus.status_i = 32'h0;
        bus.cause_i = 32'h0;       bus.epc_i = 32'h0;
        bus.bus_busy_i = 1'b0;
        idle_mem();
        repeat (3) @(negedge clk);
        tick();
        rst = 1'b1;
        tick();

        // Syscall, bus idle; stall request during flush must be ignored
        bus.mem_inst_valid_i = 1'b1; bus.mem_pc_i = 32'h80000010; bus.exc_req_i = 5'b01000;
        @(negedge clk);
        chk("sys_detect_stall", 32'(bus.stall_o), 32'h3F);
        chk("sys_detect_flush", 32'(bus.flush_o), 32'h0);
        tick(); idle_mem(); bus.stallreq_ex_i = 1'b1;
        @(negedge clk);
        chk("sys_type",   bus.exception_type_o, 32'h08);
        chk("sys_flush1", 32'(bus.flush_o),     32'h1);
        chk("sys_new_pc", bus.new_pc_o,         32'hBFC00380);
        chk("sys_exc_pc", bus.exc_pc_o,         32'h80000010);
        tick();
        @(negedge clk);
        chk("sys_type_once", bus.exception_type_o, 32'h0);
        chk("sys_flush2",    32'(bus.flush_o),     32'h1);
        chk("sys_flush_nostall", 32'(bus.stall_o), 32'h0);
        tick(); bus.stallreq_ex_i = 1'b0;
        @(negedge clk);
        chk("sys_flush_end", 32'(bus.flush_o), 32'h0);

        // ov + syscall in a delay slot: ov wins
        tick();
        bus.mem_inst_valid_i = 1'b1; bus.mem_pc_i = 32'h80000020;
        bus.mem_in_delayslot_i = 1'b1; bus.exc_req_i = 5'b01010;
        tick(); idle_mem();
        @(negedge clk);
        chk("ov_type", bus.exception_type_o,      32'h0c);
        chk("ov_ds",   32'(bus.exc_delayslot_o),  32'h1);
        repeat (3) tick();

        // Interrupt synchroniser and masked interrupt
        bus.status_i = 32'h00001001; hw_int = 6'b000100;
        @(negedge clk);
        chk("sync_0clk", 32'(int_sync), 32'h0);
        tick();
        @(negedge clk);
        chk("sync_1clk", 32'(int_sync), 32'h0);
        tick();
        @(negedge clk);
        chk("sync_2clk", 32'(int_sync), 32'h04);
        bus.cause_i = 32'h00001000; bus.mem_inst_valid_i = 1'b1; bus.mem_pc_i = 32'h80000100;
        tick(); idle_mem();
        @(negedge clk);
        chk("int_type", bus.exception_type_o, 32'h01);
        repeat (2) tick();
        bus.status_i = 32'h00001003; bus.mem_inst_valid_i = 1'b1;
        @(negedge clk);
        chk("exl_no_stall", 32'(bus.stall_o), 32'h0);
        tick(); idle_mem();
        @(negedge clk);
        chk("exl_no_flush", 32'(bus.flush_o),     32'h0);
        chk("exl_no_type",  bus.exception_type_o, 32'h0);
        bus.status_i = 32'h0; bus.cause_i = 32'h0; hw_int = 6'd0;

        // ERET held off by an outstanding bus transaction for 3 cycles
        tick();
        bus.mem_inst_valid_i = 1'b1; bus.exc_req_i = 5'b10000; bus.mem_pc_i = 32'h80000300;
        bus.epc_i = 32'h80001000; bus.bus_busy_i = 1'b1;
        @(negedge clk);
        chk("eret_wait_stall0", 32'(bus.stall_o), 32'h3F);
        for (int i = 1; i < 4; i++) begin
            tick();
            bus.exc_req_i = 5'b01000; bus.epc_i = 32'h12345678;
            if (i == 3) begin
                bus.bus_busy_i = 1'b0;
                idle_mem();
            end
            @(negedge clk);
            chk("eret_wait_stall", 32'(bus.stall_o), 32'h3F);
            chk("eret_wait_noflush", 32'(bus.flush_o), 32'h0);
        end
        tick(); bus.bus_busy_i = 1'b1;
        @(negedge clk);
        chk("eret_type",   bus.exception_type_o, 32'h0e);
        chk("eret_new_pc", bus.new_pc_o,         32'h80001000);
        chk("eret_flush",  32'(bus.flush_o),     32'h1);
        tick();
        @(negedge clk);
        chk("eret_busy_ignored", 32'(bus.flush_o), 32'h1);
        tick(); bus.bus_busy_i = 1'b0;

        // Stall request priority
        tick(); bus.stallreq_ex_i = 1'b1; bus.stallreq_id_i = 1'b1;
        @(negedge clk);
        chk("stall_ex_id", 32'(bus.stall_o), 32'h0F);
        tick(); bus.stallreq_ex_i = 1'b0; bus.stallreq_id_i = 1'b0; bus.stallreq_mem_i = 1'b1;
        @(negedge clk);
        chk("stall_mem", 32'(bus.stall_o), 32'h1F);
        tick(); bus.stallreq_mem_i = 1'b0; bus.stallreq_if_i = 1'b1;
        @(negedge clk);
        chk("stall_if", 32'(bus.stall_o), 32'h07);
        tick(); bus.stallreq_if_i = 1'b0;

        // Reset in the middle of a flush, then a clean sequence
        tick();
        bus.mem_inst_valid_i = 1'b1; bus.exc_req_i = 5'b00100; bus.mem_pc_i = 32'h80000400;
        tick(); idle_mem();
        @(negedge clk);
        chk("trap_type", bus.exception_type_o, 32'h0d);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_flush", 32'(bus.flush_o), 32'h0);
        chk("rst_mid_stall", 32'(bus.stall_o), 32'h0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        bus.mem_inst_valid_i = 1'b1; bus.exc_req_i = 5'b01000; bus.mem_pc_i = 32'h80000500;
        tick(); idle_mem();
        @(negedge clk);
        chk("post_rst_type",   bus.exception_type_o, 32'h08);
        chk("post_rst_exc_pc", bus.exc_pc_o,         32'h80000500);
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
